// File: rtl/demux_1a2_pkg.sv
// demux_1a2_pkg: shared widths and buffer state encoding for demux_1a2
package demux_1a2_pkg;
  localparam int NBITS = 32;
  localparam int CNT_W = 16;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} buf_state_t;
endpackage

// File: rtl/stream_buf2.sv
// stream_buf2: 2-entry registered stream buffer (push/push_data in; pop, out_valid/out_data/full out)
module stream_buf2
  import demux_1a2_pkg::*;
#(
  parameter int nbits = NBITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [nbits-1:0] push_data,
  input  logic             pop,
  output logic             out_valid,
  output logic [nbits-1:0] out_data,
  output logic             full
);
  buf_state_t state, state_nxt;
  logic [nbits-1:0] second;
  logic take;
  assign take = pop & out_valid;
  assign full = state == FULL;
  always_ff @(posedge clk)
    if (reset) begin
      state     <= EMPTY;
      out_valid <= 1'b0;
      out_data  <= '0;
      second    <= '0;
    end else begin
      state     <= state_nxt;
      out_valid <= state_nxt != EMPTY;
      if (push & (state == EMPTY | (state == ONE & take))) out_data <= push_data;
      else if (take & state == FULL) out_data <= second;
      if (push & state == ONE & !take) second <= push_data;
    end
  always_comb begin
    state_nxt = state;
    state_nxt = state == EMPTY ? (push ? ONE : EMPTY)
              : state == ONE   ? (push & !take ? FULL : !push & take ? EMPTY : ONE)
              :                  (take ? ONE : FULL);
  end
endmodule

// File: rtl/demux_1a2.sv
// demux_1a2: 1-to-2 stream demux (in_* stream steered by in_sel to out_a_*/out_b_*, cnt_a/cnt_b count deliveries)
module demux_1a2
  import demux_1a2_pkg::*;
#(
  parameter int nbits = NBITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [nbits-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [nbits-1:0] out_a_data,
  output logic             out_a_valid,
  input  logic             out_a_ready,
  output logic [nbits-1:0] out_b_data,
  output logic             out_b_valid,
  input  logic             out_b_ready,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);
  logic full_a, full_b, push_a, push_b;
  assign in_ready = in_sel ? !full_a : !full_b;
  assign push_a = in_valid & in_ready & in_sel;
  assign push_b = in_valid & in_ready & !in_sel;
  stream_buf2 #(.nbits(nbits)) u_buf_a (
    .clk(clk), .reset(reset), .push(push_a), .push_data(in_data), .pop(out_a_ready),
    .out_valid(out_a_valid), .out_data(out_a_data), .full(full_a)
  );
  stream_buf2 #(.nbits(nbits)) u_buf_b (
    .clk(clk), .reset(reset), .push(push_b), .push_data(in_data), .pop(out_b_ready),
    .out_valid(out_b_valid), .out_data(out_b_data), .full(full_b)
  );
  always_ff @(posedge clk)
    if (reset) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (out_a_valid & out_a_ready) cnt_a <= cnt_a + 16'd1;
      if (out_b_valid & out_b_ready) cnt_b <= cnt_b + 16'd1;
    end
endmodule

// File: tb/tb_demux_1a2.sv
// tb_demux_1a2: scoreboard bench for demux_1a2
module tb_demux_1a2;
  logic clk = 0, reset = 1;
  logic [31:0] in_data = 0, out_a_data, out_b_data;
  logic in_sel = 0, in_valid = 0, in_ready;
  logic out_a_valid, out_b_valid, out_a_ready = 0, out_b_ready = 0;
  logic [15:0] cnt_a, cnt_b, ea = 0, eb = 0, base_a, base_b;
  logic [31:0] qa[$], qb[$];
  int checks = 0, errors = 0;
  demux_1a2 dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .out_a_data(out_a_data), .out_a_valid(out_a_valid),
    .out_a_ready(out_a_ready), .out_b_data(out_b_data), .out_b_valid(out_b_valid),
    .out_b_ready(out_b_ready), .cnt_a(cnt_a), .cnt_b(cnt_b)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  always @(negedge clk)
    if (reset) begin
      qa.delete();
      qb.delete();
      ea = 0;
      eb = 0;
    end else begin
      check("in_ready", {31'd0, in_ready}, {31'd0, in_sel ? qa.size() < 2 : qb.size() < 2});
      check("a_valid", {31'd0, out_a_valid}, {31'd0, qa.size() != 0});
      check("b_valid", {31'd0, out_b_valid}, {31'd0, qb.size() != 0});
      if (qa.size() != 0) check("a_data", out_a_data, qa[0]);
      if (qb.size() != 0) check("b_data", out_b_data, qb[0]);
      check("cnt_a", {16'd0, cnt_a}, {16'd0, ea});
      check("cnt_b", {16'd0, cnt_b}, {16'd0, eb});
      if (out_a_valid && out_a_ready && qa.size() != 0) begin
        void'(qa.pop_front());
        ea++;
      end
      if (out_b_valid && out_b_ready && qb.size() != 0) begin
        void'(qb.pop_front());
        eb++;
      end
      if (in_valid && in_ready) begin
        if (in_sel) qa.push_back(in_data);
        else qb.push_back(in_data);
      end
    end
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    in_valid = 0;
    reset = 1;
    cycle();
    reset = 0;
  endtask
  task automatic send(input logic s, input logic [31:0] d);
    in_valid = 1;
    in_sel = s;
    in_data = d;
    #1;
    for (int i = 0; i < 20; i++) begin
      if (in_ready) begin
        cycle();
        in_valid = 0;
        return;
      end
      cycle();
    end
    check("send_timeout", 0, 1);
    in_valid = 0;
  endtask
  task automatic drain();
    in_valid = 0;
    out_a_ready = 1;
    out_b_ready = 1;
    for (int i = 0; i < 10 && qa.size() + qb.size() != 0; i++) cycle();
    cycle();
    check("drain", qa.size() + qb.size(), 0);
  endtask
  initial begin
    cycle();
    do_reset();
    check("rst_a_valid", {31'd0, out_a_valid}, 0);
    check("rst_b_valid", {31'd0, out_b_valid}, 0);
    check("rst_a_data", out_a_data, 0);
    check("rst_b_data", out_b_data, 0);
    check("rst_cnt", {cnt_a, cnt_b}, 0);
    check("rst_in_ready", {31'd0, in_ready}, 1);
    out_a_ready = 1;
    send(1, 32'hDEADBEEF);
    check("first_a_valid", {31'd0, out_a_valid}, 1);
    check("first_a_data", out_a_data, 32'hDEADBEEF);
    check("first_b_valid", {31'd0, out_b_valid}, 0);
    cycle();
    check("first_cnt_a", {16'd0, cnt_a}, 1);
    out_a_ready = 0;
    send(1, 32'hA1);
    send(1, 32'hA2);
    in_sel = 1;
    #1;
    check("full_rdy_sel1", {31'd0, in_ready}, 0);
    in_sel = 0;
    #1;
    check("full_rdy_sel0", {31'd0, in_ready}, 1);
    send(0, 32'hB1);
    check("b1_valid", {31'd0, out_b_valid}, 1);
    check("b1_data", out_b_data, 32'hB1);
    check("a_hold_data", out_a_data, 32'hA1);
    out_a_ready = 1;
    send(1, 32'hA3);
    drain();
    base_a = cnt_a;
    base_b = cnt_b;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1;
      in_sel = i % 2 == 0;
      in_data = 32'h100 + i;
      #1;
      check("alt_in_ready", {31'd0, in_ready}, 1);
      cycle();
    end
    drain();
    check("alt_cnt_a", {16'd0, cnt_a - base_a}, 4);
    check("alt_cnt_b", {16'd0, cnt_b - base_b}, 4);
    do_reset();
    in_valid = 1;
    in_sel = 0;
    out_b_ready = 1;
    for (int i = 0; i < 65534; i++) begin
      in_data = i;
      cycle();
    end
    drain();
    check("wrap_fffe", {16'd0, cnt_b}, 32'hFFFE);
    send(0, 32'h55);
    drain();
    check("wrap_ffff", {16'd0, cnt_b}, 32'hFFFF);
    send(0, 32'h66);
    drain();
    check("wrap_0000", {16'd0, cnt_b}, 0);
    out_a_ready = 0;
    out_b_ready = 0;
    send(1, 32'hA5);
    send(1, 32'hA6);
    send(0, 32'hB5);
    send(0, 32'hB6);
    do_reset();
    check("mid_rst_valid", {30'd0, out_a_valid, out_b_valid}, 0);
    check("mid_rst_cnt", {cnt_a, cnt_b}, 0);
    check("mid_rst_data", out_a_data | out_b_data, 0);
    out_a_ready = 1;
    out_b_ready = 1;
    repeat (4) cycle();
    for (int i = 0; i < 400; i++) begin
      in_valid = $urandom_range(0, 1) == 1;
      in_sel = $urandom_range(0, 1) == 1;
      in_data = $urandom;
      out_a_ready = $urandom_range(0, 3) != 0;
      out_b_ready = $urandom_range(0, 2) == 0;
      cycle();
    end
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
